// File: rtl/core_pkg.sv
// Shared types, FSM state encoding and default vector constants for the
// CPU core's interrupt logic.
package core_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] reg16_type;

  // Sequencer FSM: IDLE tracks arbitration, SERVICE freezes the grant.
  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } seq_state_type;

  localparam reg16_type DEF_RESET_VEC   = 16'hFFFC;
  localparam reg16_type DEF_BRK_VEC     = 16'hFFFE;
  localparam reg16_type DEF_CH_VEC_BASE = 16'hFFFA;

  // Vector of channel k: base - 2*k, wrapping in 16 bits.
  function automatic reg16_type ch_vector(input reg16_type base,
                                          input logic [2:0] k);
    return base - {12'd0, k, 1'b0};
  endfunction

endpackage

// File: rtl/int_sync.sv
// Input synchroniser for one active-low interrupt line, plus a falling-edge
// detector on the synchronised value. Everything holds while I_ready is low.
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_clock,
  input  logic I_reset,
  input  logic I_ready,
  input  logic int_n,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   prev_q;

  assign level = stage_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~level;

  // Shift the raw input through the synchroniser; remember the last output.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      // NOTE: synchronisers reset to 1 so an idle (high) line never looks like an edge.
      stage_q <= '1;
      prev_q  <= 1'b1;
    end else if (I_ready) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      stage_q[0] <= int_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= level;
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: per-channel latches, fixed-priority arbitration,
// vector generation and the IDLE/SERVICE handshake with the core.
module irq_sequencer
  import core_pkg::*;
#(
  parameter int        CHANNELS    = 4,
  parameter reg8_type  EDGE_MASK   = 8'h01,
  parameter reg8_type  NMI_MASK    = 8'h01,
  parameter int        SYNC_STAGES = 2,
  parameter reg16_type RESET_VEC   = DEF_RESET_VEC,
  parameter reg16_type BRK_VEC     = DEF_BRK_VEC,
  parameter reg16_type CH_VEC_BASE = DEF_CH_VEC_BASE
) (
  input  logic                I_clock,
  input  logic                I_reset,
  input  logic                I_ready,
  input  logic [CHANNELS-1:0] I_int_n,
  input  logic                I_iflag,
  input  logic                I_ack,
  input  logic                I_done,
  output logic                O_pending,
  output logic [15:0]         O_vector,
  output logic [2:0]          O_channel,
  output logic                O_is_reset,
  output logic                O_is_soft,
  output logic                O_busy
);

  logic [CHANNELS-1:0] sync_level;
  logic [CHANNELS-1:0] sync_fall;
  logic [CHANNELS-1:0] edge_latch_q, edge_latch_d;
  logic [CHANNELS-1:0] request;
  logic                reset_latch_q, reset_latch_d;
  logic                clear_grant;

  logic                arb_pending;
  logic                arb_found;
  logic [2:0]          arb_channel;
  reg16_type           arb_vector;

  seq_state_type       state_q, state_d;
  logic                update_grant;

  // One synchroniser/edge detector per interrupt line.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_sync
    int_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .I_clock (I_clock),
      .I_reset (I_reset),
      .I_ready (I_ready),
      .int_n   (I_int_n[k]),
      .level   (sync_level[k]),
      .fall    (sync_fall[k])
    );
  end

  // The granted source is released only when a real grant is acknowledged.
  assign clear_grant = (state_q == IDLE) && I_ack && O_pending;

  // Next latch values and requests; a new edge beats a simultaneous clear.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    reset_latch_d = reset_latch_q;
    edge_latch_d  = '0;
    request       = '0;
    if (clear_grant && O_is_reset) reset_latch_d = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (EDGE_MASK[k]) begin
        edge_latch_d[k] = sync_fall[k] |
                          (edge_latch_q[k] &
                           ~(clear_grant && !O_is_reset && (O_channel == 3'(k))));
        request[k]      = edge_latch_d[k];
      end else begin
        request[k]      = ~sync_level[k];
      end
      if (!NMI_MASK[k] && I_iflag) request[k] = 1'b0;
    end
  end

  // Fixed priority: reset first, then the lowest-numbered requesting channel.
  always_comb begin
    arb_found   = 1'b0;
    arb_channel = 3'd0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (request[k]) begin
        arb_found   = 1'b1;
        arb_channel = 3'(k);
      end
    end
    arb_pending = reset_latch_d | arb_found;
    if (reset_latch_d) begin
      arb_channel = 3'd0;
      arb_vector  = RESET_VEC;
    end else if (arb_found) begin
      arb_vector  = ch_vector(CH_VEC_BASE, arb_channel);
    end else begin
      arb_vector  = BRK_VEC;
    end
  end

  // FSM next state; the grant outputs follow arbitration unless a service is running.
  always_comb begin
    state_d      = state_q;
    update_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (I_ack) state_d = SERVICE;
        else       update_grant = 1'b1;
      end
      SERVICE: begin
        if (I_done) begin
          state_d      = IDLE;
          update_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latches and FSM state, enabled by I_ready.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      reset_latch_q <= 1'b1;
      edge_latch_q  <= '0;
      state_q       <= IDLE;
    end else if (I_ready) begin
      reset_latch_q <= reset_latch_d;
      edge_latch_q  <= edge_latch_d;
      state_q       <= state_d;
    end
  end

  // Registered outputs: pending always tracks, the grant is frozen in SERVICE.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      O_pending  <= 1'b1;
      O_vector   <= RESET_VEC;
      O_channel  <= 3'd0;
      O_is_reset <= 1'b1;
      O_is_soft  <= 1'b0;
    end else if (I_ready) begin
      O_pending <= arb_pending;
      if (update_grant) begin
        O_vector   <= arb_vector;
        O_channel  <= arb_channel;
        O_is_reset <= reset_latch_d;
        O_is_soft  <= ~arb_pending;
      end
    end
  end

  assign O_busy = (state_q == SERVICE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: stimulus pushes time-stamped expectations
// into a scoreboard, a monitor compares them against the outputs on negedges.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [3:0]  int_n;
  logic        iflag;
  logic        ack;
  logic        done;
  logic        pending;
  logic [15:0] vector;
  logic [2:0]  channel;
  logic        is_reset;
  logic        is_soft;
  logic        busy;

  typedef enum int {S_PEND, S_VEC, S_CHAN, S_RST, S_SOFT, S_BUSY} sel_e;

  typedef struct {
    int          cyc;
    string       name;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  irq_sequencer dut (
    .I_clock    (clk),
    .I_reset    (rst_n),
    .I_ready    (ready),
    .I_int_n    (int_n),
    .I_iflag    (iflag),
    .I_ack      (ack),
    .I_done     (done),
    .O_pending  (pending),
    .O_vector   (vector),
    .O_channel  (channel),
    .O_is_reset (is_reset),
    .O_is_soft  (is_soft),
    .O_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [15:0] actual(input sel_e sel);
    case (sel)
      S_PEND:  return {15'd0, pending};
      S_VEC:   return vector;
      S_CHAN:  return {13'd0, channel};
      S_RST:   return {15'd0, is_reset};
      S_SOFT:  return {15'd0, is_soft};
      default: return {15'd0, busy};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
  endtask

  // Monitor: compare every expectation due on this cycle, then drop it.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cycle_cnt) begin
        check(sb[i].name, actual(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect1(input int dly, input string name, input sel_e sel, input logic [15:0] v);
    exp_t e;
    e.cyc  = cycle_cnt + dly;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_grant(input int dly, input string tag, input logic p,
                              input logic [15:0] v, input logic [2:0] ch,
                              input logic r, input logic s, input logic b);
    expect1(dly, {tag, ".pending"}, S_PEND, {15'd0, p});
    expect1(dly, {tag, ".vector"},  S_VEC,  v);
    expect1(dly, {tag, ".channel"}, S_CHAN, {13'd0, ch});
    expect1(dly, {tag, ".is_reset"}, S_RST, {15'd0, r});
    expect1(dly, {tag, ".is_soft"}, S_SOFT, {15'd0, s});
    expect1(dly, {tag, ".busy"},    S_BUSY, {15'd0, b});
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; int_n = 4'hF; iflag = 1'b1; ack = 1'b0; done = 1'b0;
    tick(3);

    // Reset release, then an acknowledged reset and a soft grant.
    rst_n = 1'b1;
    expect_grant(1, "rst", 1'b1, 16'hFFFC, 3'd0, 1'b1, 1'b0, 1'b0);
    tick(1); ack = 1'b1;
    expect_grant(1, "rst_ack", 1'b0, 16'hFFFC, 3'd0, 1'b1, 1'b0, 1'b1);
    tick(1); ack = 1'b0; done = 1'b1;
    expect_grant(1, "rst_done", 1'b0, 16'hFFFE, 3'd0, 1'b0, 1'b1, 1'b0);
    tick(1); done = 1'b0;

    // Ch0 edge NMI with I_iflag=1: latency, grant, clear, no retrigger.
    int_n[0] = 1'b0;
    expect1(2, "ch0_early", S_PEND, 16'd0);
    expect_grant(3, "ch0", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(3); ack = 1'b1;
    expect_grant(1, "ch0_ack", 1'b0, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(1); ack = 1'b0; done = 1'b1;
    expect_grant(1, "ch0_done", 1'b0, 16'hFFFE, 3'd0, 1'b0, 1'b1, 1'b0);
    tick(1); done = 1'b0;
    expect1(4, "ch0_noretrig", S_PEND, 16'd0);
    tick(4); int_n[0] = 1'b1;
    tick(4);

    // Ch1 level maskable: masked, unmasked, released.
    int_n[1] = 1'b0;
    expect1(4, "ch1_masked", S_PEND, 16'd0);
    tick(4); iflag = 1'b0;
    expect_grant(1, "ch1", 1'b1, 16'hFFF8, 3'd1, 1'b0, 1'b0, 1'b0);
    tick(1); int_n[1] = 1'b1;
    expect1(2, "ch1_hold", S_PEND, 16'd1);
    expect_grant(3, "ch1_release", 1'b0, 16'hFFFE, 3'd0, 1'b0, 1'b1, 1'b0);
    tick(4);

    // Ch0 edge and ch2 level together: ch0 first, ch2 after service.
    int_n[0] = 1'b0; int_n[2] = 1'b0;
    expect_grant(3, "ch0_ch2", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(3); ack = 1'b1;
    expect_grant(1, "ch0_ch2_ack", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(1); ack = 1'b0; done = 1'b1;
    expect_grant(1, "ch2_after", 1'b1, 16'hFFF6, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1); done = 1'b0; int_n[0] = 1'b1; int_n[2] = 1'b1; iflag = 1'b1;
    expect1(4, "idle_clear", S_PEND, 16'd0);
    tick(4);

    // New ch0 edge coinciding with I_ack: set wins, ack in SERVICE ignored.
    int_n[0] = 1'b0;
    expect1(3, "sw_first", S_VEC, 16'hFFFA);
    tick(3); int_n[0] = 1'b1;
    tick(3); int_n[0] = 1'b0;
    tick(2); ack = 1'b1;
    expect_grant(1, "sw_ack", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(1);
    expect_grant(1, "sw_svc", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(1); ack = 1'b0; done = 1'b1;
    expect_grant(1, "sw_done", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1); done = 1'b0; ack = 1'b1;
    expect1(1, "sw_clear", S_PEND, 16'd0);
    tick(1); ack = 1'b0; done = 1'b1;
    tick(1); done = 1'b0; int_n[0] = 1'b1;
    tick(4);

    // I_ready low across a ch0 edge, then reset pulsed mid-SERVICE.
    ready = 1'b0; int_n[0] = 1'b0;
    expect1(5, "rdy_hold", S_PEND, 16'd0);
    tick(5); ready = 1'b1;
    expect1(2, "rdy_lat", S_PEND, 16'd0);
    expect_grant(3, "rdy_edge", 1'b1, 16'hFFFA, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(3); ack = 1'b1;
    expect1(1, "mid_busy", S_BUSY, 16'd1);
    tick(1); ack = 1'b0; rst_n = 1'b0;
    expect_grant(1, "rst_mid", 1'b1, 16'hFFFC, 3'd0, 1'b1, 1'b0, 1'b0);
    tick(1); rst_n = 1'b1;
    tick(4);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Parametrised interrupt sequencer for the CPU core. It generalises the fixed IRQ/NMI/RESET logic into CHANNELS interrupt sources, each with a per-channel mode (falling-edge latched or level, maskable or non-maskable). It arbitrates by fixed priority and presents the vector address at each instruction boundary. It sits beside the core: the core samples O_pending/O_vector at T0 and acknowledges with I_ack on the T0 latch strobe.

## Interface

Parameters:
- CHANNELS, 4, number of interrupt sources (1..8); channel 0 has highest priority.
- EDGE_MASK, 8'h01, bit k=1: channel k is falling-edge latched; 0: level (active low).
- NMI_MASK, 8'h01, bit k=1: channel k ignores I_iflag.
- SYNC_STAGES, 2, synchroniser depth per input (≥1).
- RESET_VEC, 16'hFFFC, vector after reset.
- BRK_VEC, 16'hFFFE, vector when nothing is pending (software BRK).
- CH_VEC_BASE, 16'hFFFA, vector of channel k = CH_VEC_BASE − 2·k (16-bit wrap).

Ports:
- I_clock  in  1  system clock.
- I_reset  in  1  asynchronous, active-low reset.
- I_ready  in  1  clock enable; when low, all state holds.
- I_int_n  in  CHANNELS  interrupt requests, active low, asynchronous.
- I_iflag  in  1  CPU P[I]; 1 masks maskable channels.
- I_ack  in  1  one-clock strobe: core latches the vector and begins the interrupt sequence.
- I_done  in  1  one-clock strobe: vector fetch complete (end of the sequence).
- O_pending  out  1  a hardware interrupt or reset is requested.
- O_vector  out  16  vector low-byte address.
- O_channel  out  3  granted channel index (0 when reset or soft).
- O_is_reset  out  1  the grant is the reset vector.
- O_is_soft  out  1  no hardware source is granted (BRK path).
- O_busy  out  1  FSM is in SERVICE.

## Operation

- Each input passes through SYNC_STAGES flops. An edge channel sets its latch when the synchronised value goes 1→0.
- Request of channel k:
  - Edge channel: the latch.
  - Level channel: the synchronised input is 0.
  - A channel whose NMI_MASK bit is 0 also requires I_iflag=0.
  - A masked latched edge stays latched.
- The reset latch is set by I_reset low. Priority: reset > channel 0 > … > channel CHANNELS−1.
- FSM states:
  - IDLE:
    - Registered outputs track arbitration every enabled clock.
    - I_ack moves the FSM to SERVICE.
    - If O_pending=1 when I_ack arrives, the granted source is cleared: the reset latch, or the edge latch of the granted channel. Level channels are not cleared.
    - If O_pending=0, the grant is soft: O_is_soft=1 and O_vector=BRK_VEC.
  - SERVICE:
    - O_vector, O_channel, O_is_reset and O_is_soft are frozen.
    - Latches keep collecting new requests.
    - I_done returns the FSM to IDLE.
    - I_ack while in SERVICE is ignored.
- Simultaneous new falling edge and I_ack clearing the same channel: the set wins, and the channel is still pending after SERVICE.
- I_done and I_ack in the same clock while in IDLE: I_ack is honoured and I_done is ignored.
- I_reset asserted mid-SERVICE: the FSM returns immediately to IDLE in the reset state.

## Timing

- Reset values:
  - O_pending=1, O_vector=RESET_VEC, O_is_reset=1.
  - O_channel=0, O_is_soft=0, O_busy=0.
  - Edge latches 0; synchronisers 1 (inactive).
- Outputs are registered. Latency from an input edge to O_pending is SYNC_STAGES+1 enabled clocks. I_iflag affects O_pending one enabled clock later.
- Source clearing takes effect on the clock after I_ack. O_busy rises on the same clock edge.
- With I_ready low, synchronisers, latches, FSM and outputs all hold. A pulse shorter than the ready-low window plus SYNC_STAGES clocks may be missed.

## Structure

- Shared package core_pkg holds reg8_type/reg16_type, the FSM state enum (IDLE, SERVICE), and default vector constants.
- One sub-module, int_sync: SYNC_STAGES synchroniser plus falling-edge detector with an I_ready enable, instantiated per channel via generate.
- The top level contains the latches, priority encoder, vector arithmetic and FSM.

## Test plan

- Reset release, no inputs → O_pending=1, O_vector=FFFC, O_is_reset=1. I_ack then I_done → O_pending=0, O_vector=FFFE, O_is_soft=1.
- Ch0 (edge, NMI) falls with I_iflag=1 → O_pending=1 after 3 clocks, O_vector=FFFA, O_channel=0. I_ack → latch cleared. Input held low → no retrigger.
- Ch1 (level, maskable) low with I_iflag=1 → O_pending=0. Set I_iflag=0 → O_pending=1, O_vector=FFF8. Release input before I_ack → O_pending=0.
- Ch0 edge and ch2 level at once → ch0 granted (FFFA). After I_done → ch2 granted (FFF6).
- New ch0 edge on the I_ack clock → O_vector frozen at FFFA through SERVICE. After I_done, O_pending=1 and ch0 is granted again.
- I_ready low during a ch0 edge → no change until I_ready rises. I_reset pulsed mid-SERVICE → O_busy=0, O_vector=FFFC.
